fb_write_slave: RTL and testbench

AXI4-Lite write-only slave that terminates the accelerator's master write port and stores rendered pixel words into a framebuffer memory. It accepts one write transaction at a time, with address and data taken in either order, decodes the address against the framebuffer window, issues a single-cycle memory write, and returns a write response. It sits between the accelerator's master write channels and the framebuffer RAM write port.

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_addr_decode.sv | 27 ++
 rtl/fb_write_slave.sv | 151 +++++++++++++++
 tb/tb_fb_write_slave.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types used by the write slave and its
// sibling render/transform units.
package fb_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [31:0] FB_BASE_DEFAULT  = 32'h0000_0000;
   localparam int unsigned FB_WORDS_DEFAULT = 32'd76800;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RESP  = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_addr_decode.sv
// Maps a byte address onto the framebuffer window: in-range/aligned flag plus
// the word index. Pure combinational so a read slave can reuse it.
module fb_addr_decode
   import fb_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  FB_BASE    = ADDR_WIDTH'(FB_BASE_DEFAULT),
   parameter int unsigned            FB_WORDS   = FB_WORDS_DEFAULT,
   parameter int unsigned            MEM_AW     = 17
)(
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  valid,
   output logic [MEM_AW-1:0]     index
);

   localparam logic [ADDR_WIDTH-1:0] WORDS = ADDR_WIDTH'(FB_WORDS);

   logic [ADDR_WIDTH-1:0] word_s;

   // Full-width compare so addresses below the base never wrap into range.
   always_comb begin
      word_s = (addr - FB_BASE) >> 2'd2;
      valid  = (addr >= FB_BASE) && (addr[1:0] == 2'b00) && (word_s < WORDS);
      index  = word_s[MEM_AW-1:0];
   end

endmodule

// File: rtl/fb_write_slave.sv
// AXI4-Lite write-only slave feeding the framebuffer RAM write port. One
// transaction in flight; AW and W may arrive in either order.
module fb_write_slave
   import fb_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  FB_BASE    = ADDR_WIDTH'(FB_BASE_DEFAULT),
   parameter int unsigned            FB_WORDS   = FB_WORDS_DEFAULT,
   parameter int unsigned            MEM_AW     = 17
)(
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic [ADDR_WIDTH-1:0]     AWADDR,
   input  logic [2:0]                AWPROT,
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [DATA_WIDTH-1:0]     WDATA,
   input  logic [DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                      WVALID,
   output logic                      WREADY,
   output logic [1:0]                BRESP,
   output logic                      BVALID,
   input  logic                      BREADY,
   output logic                      mem_we,
   output logic [MEM_AW-1:0]         mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_wstrb,
   output logic [15:0]               wr_count
);

   fb_state_e                state_r, state_nxt_s;
   logic                     aw_held_r, aw_held_nxt_s, w_held_r, w_held_nxt_s;
   logic [ADDR_WIDTH-1:0]    addr_r, addr_nxt_s;
   logic [DATA_WIDTH-1:0]    data_r, data_nxt_s;
   logic [DATA_WIDTH/8-1:0]  strb_r, strb_nxt_s;
   logic                     aw_hs_s, w_hs_s, b_hs_s, enter_write_s;
   logic                     addr_ok_s;
   logic [MEM_AW-1:0]        index_s;

   logic                     awready_r, awready_nxt_s, wready_r, wready_nxt_s;
   logic                     bvalid_r, bvalid_nxt_s, mem_we_r, mem_we_nxt_s;
   logic [1:0]               bresp_r, bresp_nxt_s;
   logic [MEM_AW-1:0]        mem_addr_r, mem_addr_nxt_s;
   logic [31:0]              mem_wdata_r, mem_wdata_nxt_s;
   logic [3:0]               mem_wstrb_r, mem_wstrb_nxt_s;
   logic [15:0]              wr_count_r, wr_count_nxt_s;
   logic                     unused_ok;

   assign unused_ok = ^AWPROT;

   // Decode the address as it will be held after this edge, so the memory
   // write can be registered in the same edge as the last handshake.
   fb_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .FB_BASE    (FB_BASE),
      .FB_WORDS   (FB_WORDS),
      .MEM_AW     (MEM_AW)
   ) u_decode (
      .addr  (addr_nxt_s),
      .valid (addr_ok_s),
      .index (index_s)
   );

   // State and transaction-holding registers.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_r   <= IDLE;
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
         addr_r    <= '0;
         data_r    <= '0;
         strb_r    <= '0;
      end else begin
         state_r   <= state_nxt_s;
         aw_held_r <= aw_held_nxt_s;
         w_held_r  <= w_held_nxt_s;
         addr_r    <= addr_nxt_s;
         data_r    <= data_nxt_s;
         strb_r    <= strb_nxt_s;
      end
   end

   // Handshakes, held-channel bookkeeping and next state.
   always_comb begin
      aw_hs_s       = AWVALID && awready_r;
      w_hs_s        = WVALID && wready_r;
      b_hs_s        = BREADY && bvalid_r;
      aw_held_nxt_s = !b_hs_s && (aw_held_r || aw_hs_s);
      w_held_nxt_s  = !b_hs_s && (w_held_r || w_hs_s);
      addr_nxt_s    = aw_hs_s ? AWADDR : addr_r;
      data_nxt_s    = w_hs_s ? WDATA : data_r;
      strb_nxt_s    = w_hs_s ? WSTRB : strb_r;
      case (state_r)
         IDLE:    state_nxt_s = (aw_held_nxt_s && w_held_nxt_s) ? WRITE : IDLE;
         WRITE:   state_nxt_s = RESP;
         RESP:    state_nxt_s = b_hs_s ? IDLE : RESP;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      enter_write_s   = (state_r == IDLE) && (state_nxt_s == WRITE);
      awready_nxt_s   = (state_nxt_s == IDLE) && !aw_held_nxt_s;
      wready_nxt_s    = (state_nxt_s == IDLE) && !w_held_nxt_s;
      bvalid_nxt_s    = (state_nxt_s == RESP);
      mem_we_nxt_s    = enter_write_s && addr_ok_s && (|strb_nxt_s);
      bresp_nxt_s     = enter_write_s ? (addr_ok_s ? RESP_OKAY : RESP_SLVERR) : bresp_r;
      mem_addr_nxt_s  = mem_we_nxt_s ? index_s : mem_addr_r;
      mem_wdata_nxt_s = mem_we_nxt_s ? data_nxt_s : mem_wdata_r;
      mem_wstrb_nxt_s = mem_we_nxt_s ? strb_nxt_s : mem_wstrb_r;
      wr_count_nxt_s  = ((state_r == WRITE) && mem_we_r) ? (wr_count_r + 16'd1) : wr_count_r;
   end

   // Output registers.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         awready_r   <= 1'b0;
         wready_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         bresp_r     <= RESP_OKAY;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'h0000_0000;
         mem_wstrb_r <= 4'h0;
         wr_count_r  <= 16'h0000;
      end else begin
         awready_r   <= awready_nxt_s;
         wready_r    <= wready_nxt_s;
         bvalid_r    <= bvalid_nxt_s;
         bresp_r     <= bresp_nxt_s;
         mem_we_r    <= mem_we_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_wdata_r <= mem_wdata_nxt_s;
         mem_wstrb_r <= mem_wstrb_nxt_s;
         wr_count_r  <= wr_count_nxt_s;
      end
   end

   assign AWREADY   = awready_r;
   assign WREADY    = wready_r;
   assign BVALID    = bvalid_r;
   assign BRESP     = bresp_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_wstrb = mem_wstrb_r;
   assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_fb_write_slave.sv
// Bench for fb_write_slave: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fb_write_slave;
   import fb_pkg::*;

   localparam longint unsigned FBB   = 64'h0;
   localparam longint unsigned WORDS = 64'd76800;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID, WREADY;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;
   logic        mem_we;
   logic [16:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [15:0] wr_count;

   always #5 ACLK = ~ACLK;

   fb_write_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .wr_count(wr_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
      longint unsigned x;
      x = a;
      return (x >= FBB) && (x % 4 == 0) && ((x - FBB) / 4 < WORDS);
   endfunction

   // Reference model: tracks which channels the slave has taken and when the
   // write/response events are due, in terms of handshake events.
   bit          m_on = 1'b0, m_rst = 1'b0;
   bit          m_aw, m_w, m_inwr, m_we, m_bv, m_awr, m_wr;
   logic [31:0] m_addr, m_data, m_mdata;
   logic [3:0]  m_strb, m_mstrb;
   logic [1:0]  m_br;
   logic [15:0] m_cnt;
   logic [16:0] m_maddr;

   always @(posedge ACLK) begin
      bit hs_aw, hs_w, hs_b, pre_we, pre_in;
      m_on = 1'b1;
      if (!ARESETn) begin
         m_rst = 1'b1; m_aw = 1'b0; m_w = 1'b0; m_inwr = 1'b0; m_we = 1'b0;
         m_bv = 1'b0; m_awr = 1'b0; m_wr = 1'b0; m_br = 2'b00; m_cnt = 16'h0;
         m_maddr = 17'h0; m_mdata = 32'h0; m_mstrb = 4'h0;
      end else begin
         hs_aw  = AWVALID && m_awr;
         hs_w   = WVALID && m_wr;
         hs_b   = BREADY && m_bv;
         pre_we = m_we;
         pre_in = m_inwr;
         m_rst  = 1'b0;
         m_we   = 1'b0;
         m_inwr = 1'b0;
         if (pre_we) m_cnt = m_cnt + 16'd1;
         if (pre_in) m_bv = 1'b1;
         if (hs_b) begin m_bv = 1'b0; m_aw = 1'b0; m_w = 1'b0; end
         if (hs_aw) begin m_aw = 1'b1; m_addr = AWADDR; end
         if (hs_w) begin m_w = 1'b1; m_data = WDATA; m_strb = WSTRB; end
         if ((hs_aw || hs_w) && m_aw && m_w) begin
            m_inwr = 1'b1;
            m_br   = addr_ok(m_addr) ? 2'b00 : 2'b10;
            if (addr_ok(m_addr) && m_strb != 4'h0) begin
               m_we    = 1'b1;
               m_maddr = 17'((longint'(m_addr) - FBB) / 4);
               m_mdata = m_data;
               m_mstrb = m_strb;
            end
         end
         m_awr = !m_aw;
         m_wr  = !m_w;
      end
   end

   int          we_pulses = 0;
   logic [16:0] last_maddr = 17'h0;
   logic [31:0] last_mdata = 32'h0;
   logic [1:0]  last_bresp = 2'b11;

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge ACLK) begin
      if (m_on) begin
         chk("awready", AWREADY, m_awr);
         chk("wready", WREADY, m_wr);
         chk("bvalid", BVALID, m_bv);
         chk("mem_we", mem_we, m_we);
         chk("wr_count", wr_count, m_cnt);
         if (m_bv || m_rst) chk("bresp", BRESP, m_br);
         if (m_we || m_rst) begin
            chk("mem_addr", mem_addr, m_maddr);
            chk("mem_wdata", mem_wdata, m_mdata);
            chk("mem_wstrb", mem_wstrb, m_mstrb);
         end
         if (mem_we) begin
            we_pulses++;
            last_maddr = mem_addr;
            last_mdata = mem_wdata;
         end
         if (BVALID && BREADY) last_bresp = BRESP;
      end
   end

   // One transaction with per-channel start delays; optionally keeps AWVALID
   // high with the next address after the AW handshake.
   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int aw_dly, input int w_dly, input int b_dly,
                       input bit hold, input logic [31:0] nxt);
      bit aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0;
      bit p_aw, p_w, p_b;
      int k = 0;
      AWADDR = a; WDATA = d; WSTRB = s; AWPROT = 3'($urandom_range(0, 7));
      while (!b_done && k < 60) begin
         if (!aw_done) AWVALID = (k >= aw_dly);
         WVALID = !w_done && (k >= w_dly);
         BREADY = (k >= b_dly);
         @(negedge ACLK);
         p_aw = AWVALID && AWREADY;
         p_w  = WVALID && WREADY;
         p_b  = BVALID && BREADY;
         @(posedge ACLK);
         #1;
         if (p_aw && !aw_done) begin
            aw_done = 1'b1;
            if (hold) AWADDR = nxt;
            else AWVALID = 1'b0;
         end
         if (p_w) w_done = 1'b1;
         if (p_b) b_done = 1'b1;
         k++;
      end
      chk("xfer_completed", b_done, 1'b1);
      if (!hold) AWVALID = 1'b0;
      WVALID = 1'b0;
      BREADY = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, sel;
      logic [31:0] a;
      logic [3:0]  s;
      ARESETn = 1'b0; AWADDR = 32'h0; AWPROT = 3'h0; AWVALID = 1'b0;
      WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0;
      repeat (3) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      @(posedge ACLK); #1;
      chk("post_reset_awready", AWREADY, 1'b1);
      chk("post_reset_wready", WREADY, 1'b1);

      // Same-cycle AW/W.
      p0 = we_pulses;
      xfer(32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 32'h0);
      chk("t1_pulses", we_pulses - p0, 1);
      chk("t1_addr", last_maddr, 17'd4);
      chk("t1_data", last_mdata, 32'hDEADBEEF);
      chk("t1_resp", last_bresp, 2'b00);
      chk("t1_count", wr_count, 16'd1);
      chk("t1_model_count", m_cnt, 16'd1);

      // W first, AW three cycles later.
      p0 = we_pulses;
      xfer(32'h0000_0020, 32'h12345678, 4'hF, 3, 0, 0, 1'b0, 32'h0);
      chk("t2_pulses", we_pulses - p0, 1);
      chk("t2_addr", last_maddr, 17'd8);
      chk("t2_data", last_mdata, 32'h12345678);

      // Out-of-range and misaligned.
      p0 = we_pulses;
      xfer(32'h0004_B000, 32'h1, 4'hF, 0, 0, 0, 1'b0, 32'h0);
      chk("t3_range_resp", last_bresp, 2'b10);
      xfer(32'h0000_0002, 32'h2, 4'hF, 1, 0, 0, 1'b0, 32'h0);
      chk("t3_align_resp", last_bresp, 2'b10);
      chk("t3_pulses", we_pulses - p0, 0);
      chk("t3_count", wr_count, 16'd2);

      // BREADY low for 5 BVALID cycles with the next AW already pending.
      xfer(32'h0000_0040, 32'hCAFE0001, 4'hF, 0, 0, 7, 1'b1, 32'h0000_0044);
      chk("t4_count_a", wr_count, 16'd3);
      xfer(32'h0000_0044, 32'hCAFE0002, 4'h3, 0, 2, 0, 1'b0, 32'h0);
      chk("t4_addr", last_maddr, 17'd17);
      chk("t4_count_b", wr_count, 16'd4);

      // Zero strobes at a valid address.
      p0 = we_pulses;
      xfer(32'h0000_0050, 32'h55, 4'h0, 0, 0, 0, 1'b0, 32'h0);
      chk("t5_pulses", we_pulses - p0, 0);
      chk("t5_resp", last_bresp, 2'b00);
      chk("t5_count", wr_count, 16'd4);

      // Counter wrap, preloaded near the top to keep the run short.
      #1 force dut.wr_count_r = 16'hFFFE;
      m_cnt = 16'hFFFE;
      #1 release dut.wr_count_r;
      xfer(32'h0000_0100, 32'h1, 4'hF, 0, 0, 0, 1'b0, 32'h0);
      chk("wrap_ffff", wr_count, 16'hFFFF);
      xfer(32'h0000_0104, 32'h2, 4'hF, 0, 0, 0, 1'b0, 32'h0);
      chk("wrap_zero", wr_count, 16'h0000);
      xfer(32'h0004_AFFC, 32'h3, 4'hF, 0, 0, 0, 1'b0, 32'h0);
      chk("wrap_one", wr_count, 16'h0001);
      chk("last_word_addr", last_maddr, 17'd76799);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) a = (32'($urandom_range(0, 76799)) << 2) | 32'($urandom_range(1, 3));
         else if (sel == 1) begin
            a = $urandom & 32'hFFFF_FFFC;
            if (a < 32'h0004_B000) a = a | 32'h8000_0000;
         end
         else if (sel == 2) a = ($urandom_range(0, 1) == 0) ? 32'h0004_AFFC : 32'h0004_B000;
         else a = 32'($urandom_range(0, 76799)) << 2;
         s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         xfer(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 4), 1'b0, 32'h0);
      end

      // Reset while the response is pending.
      AWADDR = 32'h0000_0060; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
      @(posedge ACLK); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_pre_bvalid", BVALID, 1'b1);
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      p0 = we_pulses;
      @(posedge ACLK); #1;
      chk("rst_awready", AWREADY, 1'b1);
      chk("rst_wready", WREADY, 1'b1);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_count", wr_count, 16'd0);
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_no_stray_we", we_pulses - p0, 0);
      chk("rst_no_resp", BVALID, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
